// File: rtl/fp_to_fixed_if.sv
// Stream bundle for the float-to-fixed converter: an input channel carrying IEEE-754 words
// and an output channel carrying the fixed-point result with its saturation/NaN flags.
interface fp_to_fixed_if #(
  parameter int OUT_W = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      ieee_in;
  logic             out_valid;
  logic             out_ready;
  logic [OUT_W-1:0] fixed_out;
  logic             sat;
  logic             nan;

  modport master (
    output in_valid, ieee_in, out_ready,
    input  in_ready, out_valid, fixed_out, sat, nan
  );

  modport slave (
    input  in_valid, ieee_in, out_ready,
    output in_ready, out_valid, fixed_out, sat, nan
  );
endinterface

// File: rtl/fp_to_fixed.sv
// IEEE-754 single precision to two's-complement Q(INT_W).(FRAC_W) converter.
// Three valid/ready stages (unpack, shift, sign/saturate) sustain one word per cycle.
module fp_to_fixed #(
  parameter int INT_W  = 16,
  parameter int FRAC_W = 16
) (
  input  logic          clk,
  input  logic          rst,
  fp_to_fixed_if.slave  bus
);

  localparam int OUT_W = INT_W + FRAC_W;

  localparam logic [1:0] KIND_ZERO = 2'b00;
  localparam logic [1:0] KIND_NORM = 2'b01;
  localparam logic [1:0] KIND_INF  = 2'b10;
  localparam logic [1:0] KIND_NAN  = 2'b11;

  // Left shift applied to the 24-bit significand is e - 150 + FRAC_W.
  localparam logic signed [9:0] SH_OFF = 10'(FRAC_W - 150);
  // At this shift or beyond the significand's top bit lands at or above bit OUT_W.
  localparam logic signed [9:0] OVF_SH = 10'(OUT_W - 23);

  localparam logic [OUT_W-1:0] MAX_POS = {1'b0, {(OUT_W-1){1'b1}}};
  localparam logic [OUT_W-1:0] MIN_NEG = {1'b1, {(OUT_W-1){1'b0}}};

  function automatic logic [OUT_W-1:0] negate(input logic [OUT_W-1:0] val);
    return (~val) + {{(OUT_W-1){1'b0}}, 1'b1};
  endfunction

  logic             en1_s;
  logic             en2_s;
  logic             en3_s;

  logic             v1_r;
  logic             sign1_r;
  logic [1:0]       kind1_r;
  logic [7:0]       exp1_r;
  logic [23:0]      man1_r;
  logic [1:0]       kind1_s;

  logic             v2_r;
  logic             sign2_r;
  logic [1:0]       kind2_r;
  logic [OUT_W-1:0] mag2_r;
  logic             ovf2_r;
  logic signed [9:0] sh_s;
  logic signed [9:0] rsh_s;
  logic [OUT_W-1:0] mag_s;
  logic             ovf_s;

  logic             v3_r;
  logic [OUT_W-1:0] fixed_r;
  logic             sat_r;
  logic             nan_r;
  logic [OUT_W-1:0] fixed_s;
  logic             sat_s;
  logic             nan_s;

  // Stage load enables: a stage loads when empty or when its content moves on.
  always_comb begin
    en3_s = ~v3_r | bus.out_ready;
    en2_s = ~v2_r | en3_s;
    en1_s = ~v1_r | en2_s;
  end

  assign bus.in_ready  = en1_s;
  assign bus.out_valid = v3_r;
  assign bus.fixed_out = fixed_r;
  assign bus.sat       = sat_r;
  assign bus.nan       = nan_r;

  // S1 classification of the incoming word.
  always_comb begin
    kind1_s = KIND_NORM;
    if (bus.ieee_in[30:23] == 8'd0) begin
      kind1_s = KIND_ZERO;
    end else if (bus.ieee_in[30:23] == 8'hFF) begin
      kind1_s = (bus.ieee_in[22:0] != 23'd0) ? KIND_NAN : KIND_INF;
    end else begin
      kind1_s = KIND_NORM;
    end
  end

  // S1 register: unpacked sign, exponent, significand with hidden one.
  always_ff @(posedge clk) begin
    if (!rst) begin
      v1_r    <= 1'b0;
      sign1_r <= 1'b0;
      kind1_r <= KIND_ZERO;
      exp1_r  <= 8'd0;
      man1_r  <= 24'd0;
    end else if (en1_s) begin
      v1_r <= bus.in_valid;
      if (bus.in_valid) begin
        sign1_r <= bus.ieee_in[31];
        kind1_r <= kind1_s;
        exp1_r  <= bus.ieee_in[30:23];
        man1_r  <= {1'b1, bus.ieee_in[22:0]};
      end
    end
  end

  // S2 magnitude alignment; right shifts truncate toward zero.
  always_comb begin
    sh_s  = $signed({2'b00, exp1_r}) + SH_OFF;
    rsh_s = 10'sd0 - sh_s;
    mag_s = {OUT_W{1'b0}};
    ovf_s = 1'b0;
    if (kind1_r != KIND_NORM) begin
      mag_s = {OUT_W{1'b0}};
    end else if (sh_s >= OVF_SH) begin
      ovf_s = 1'b1;
    end else if (!sh_s[9]) begin
      mag_s = {{(OUT_W-24){1'b0}}, man1_r} << sh_s[6:0];
    end else if (rsh_s >= 10'sd24) begin
      mag_s = {OUT_W{1'b0}};
    end else begin
      mag_s = {{(OUT_W-24){1'b0}}, man1_r >> rsh_s[4:0]};
    end
  end

  // S2 register: aligned magnitude plus overflow marker.
  always_ff @(posedge clk) begin
    if (!rst) begin
      v2_r    <= 1'b0;
      sign2_r <= 1'b0;
      kind2_r <= KIND_ZERO;
      mag2_r  <= {OUT_W{1'b0}};
      ovf2_r  <= 1'b0;
    end else if (en2_s) begin
      v2_r <= v1_r;
      if (v1_r) begin
        sign2_r <= sign1_r;
        kind2_r <= kind1_r;
        mag2_r  <= mag_s;
        ovf2_r  <= ovf_s;
      end
    end
  end

  // S3 sign application and clamping; -2^(OUT_W-1) is representable exactly.
  always_comb begin
    fixed_s = {OUT_W{1'b0}};
    sat_s   = 1'b0;
    nan_s   = 1'b0;
    case (kind2_r)
      KIND_NAN: begin
        nan_s = 1'b1;
      end
      KIND_INF: begin
        fixed_s = sign2_r ? MIN_NEG : MAX_POS;
        sat_s   = 1'b1;
      end
      KIND_NORM: begin
        if (!sign2_r) begin
          if (ovf2_r || mag2_r[OUT_W-1]) begin
            fixed_s = MAX_POS;
            sat_s   = 1'b1;
          end else begin
            fixed_s = mag2_r;
          end
        end else begin
          if (ovf2_r || (mag2_r > MIN_NEG)) begin
            fixed_s = MIN_NEG;
            sat_s   = 1'b1;
          end else begin
            fixed_s = negate(mag2_r);
          end
        end
      end
      default: begin
        fixed_s = {OUT_W{1'b0}};
      end
    endcase
  end

  // S3 output register; holds while the consumer stalls.
  always_ff @(posedge clk) begin
    if (!rst) begin
      v3_r    <= 1'b0;
      fixed_r <= {OUT_W{1'b0}};
      sat_r   <= 1'b0;
      nan_r   <= 1'b0;
    end else if (en3_s) begin
      v3_r <= v2_r;
      if (v2_r) begin
        fixed_r <= fixed_s;
        sat_r   <= sat_s;
        nan_r   <= nan_s;
      end
    end
  end

endmodule
